// File: rtl/bus_arbiter.sv
// Round-robin bus-source arbiter with a per-grant hold limit.
// One idle turnaround cycle always separates consecutive grants.
module bus_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] req,
    output logic [31:0] grant_out,
    output logic        grant_valid,
    output logic [4:0]  grant_sel,
    output logic        timeout
);

    localparam logic [7:0] LIMIT = 8'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  sel_q, sel_d;
    logic [7:0]  hold_q, hold_d;
    logic [31:0] grant_q, grant_d;
    logic        timeout_q, timeout_d;

    logic [4:0]  pick;
    logic [4:0]  idx;
    logic        found;
    logic        rel;
    logic        lim;

    // First requester at or above ptr_q, wrapping 31 -> 0
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idx = ptr_q + 5'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign rel = !req[sel_q];
    assign lim = (hold_q == LIMIT);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    hold_d  = '0;
                    grant_d = 32'(1) << pick;
                end
            end
            GRANT: begin
                if (rel || lim) begin
                    state_d   = IDLE;
                    ptr_d     = sel_q + 5'd1;
                    sel_d     = '0;
                    hold_d    = '0;
                    grant_d   = '0;
                    // A simultaneous release wins over the limit
                    timeout_d = !rel;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_out   = grant_q;
    assign grant_valid = (state_q == GRANT);
    assign grant_sel   = sel_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, directed corner
// sequences and randomized traffic against a reference model.
module tb_bus_arbiter;

    localparam int HOLD = 16;
    localparam logic [31:0] BOTH = 32'h8000_0001;

    logic        clock;
    logic        clear;
    logic [31:0] req;
    logic [31:0] grant_out;
    logic        grant_valid;
    logic [4:0]  grant_sel;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clock       (clock),
        .clear       (clear),
        .req         (req),
        .grant_out   (grant_out),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel),
        .timeout     (timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: who owns the bus and for how long
    bit m_on   = 0;
    bit m_busy = 0;
    bit m_to   = 0;
    int m_src  = 0;
    int m_hold = 0;
    int m_ptr  = 0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h t=%0t", n, got, exp,
                     $time);
        end
    endtask

    task automatic model_step();
        bit r;
        bit l;
        m_to = 0;
        if (!clear) begin
            m_on   = 1;
            m_busy = 0;
            m_src  = 0;
            m_hold = 0;
            m_ptr  = 0;
        end else if (m_busy) begin
            r = !req[m_src];
            l = (m_hold == HOLD - 1);
            if (r || l) begin
                m_busy = 0;
                m_ptr  = (m_src + 1) % 32;
                m_to   = !r;
                m_src  = 0;
            end else begin
                m_hold++;
            end
        end else if (req != 0) begin
            for (int i = 0; i < 32; i++) begin
                if (req[(m_ptr + i) % 32]) begin
                    m_busy = 1;
                    m_src  = (m_ptr + i) % 32;
                    m_hold = 0;
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        logic [31:0] eg;
        @(posedge clock);
        model_step();
        #1;
        if (m_on) begin
            eg = m_busy ? (32'd1 << m_src) : 32'd0;
            chk("m_grant", grant_out, eg);
            chk("m_valid", 32'(grant_valid), 32'(m_busy));
            chk("m_sel", 32'(grant_sel), 32'(m_src));
            chk("m_timeout", 32'(timeout), 32'(m_to));
            chk("onehot", 32'($onehot0(grant_out)), 32'd1);
        end
    endtask

    task automatic expect_out(input string n, input logic [31:0] g,
                              input logic [4:0] s, input logic v,
                              input logic t);
        chk({n, "_grant"}, grant_out, g);
        chk({n, "_sel"}, 32'(grant_sel), 32'(s));
        chk({n, "_valid"}, 32'(grant_valid), 32'(v));
        chk({n, "_timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic do_reset();
        clear = 1'b0;
        req   = '0;
        tick();
        clear = 1'b1;
    endtask

    typedef struct {
        logic        clr;
        logic [31:0] rq;
        logic [31:0] g;
        logic [4:0]  s;
        logic        v;
        logic        t;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int src;
        int r;
        vecs[0] = '{1'b0, 32'h00, 32'h00, 5'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h08, 32'h08, 5'd3, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h08, 32'h08, 5'd3, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h08, 32'h08, 5'd3, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h08, 32'h08, 5'd3, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h00, 32'h00, 5'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h18, 32'h10, 5'd4, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 32'h18, 32'h10, 5'd4, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 32'h08, 32'h00, 5'd0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 32'h08, 32'h08, 5'd3, 1'b1, 1'b0};

        clear = 1'b0;
        req   = '0;
        foreach (vecs[i]) begin
            clear = vecs[i].clr;
            req   = vecs[i].rq;
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].g,
                       vecs[i].s, vecs[i].v, vecs[i].t);
        end

        // Reset in the middle of a grant to source 7
        do_reset();
        req = 32'h80;
        tick();
        expect_out("rst_pre", 32'h80, 5'd7, 1'b1, 1'b0);
        tick();
        tick();
        clear = 1'b0;
        tick();
        expect_out("rst_lo1", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("rst_lo2", 32'h0, 5'd0, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        expect_out("rst_hi", 32'h80, 5'd7, 1'b1, 1'b0);

        // Round-robin between sources 0 and 31
        do_reset();
        for (int k = 0; k < 4; k++) begin
            src = (k % 2) ? 31 : 0;
            req = BOTH;
            for (int c = 0; c < 3; c++) begin
                tick();
                expect_out($sformatf("rr%0d", k), 32'd1 << src,
                           5'(src), 1'b1, 1'b0);
            end
            req = BOTH & ~(32'd1 << src);
            tick();
            expect_out($sformatf("rr_gap%0d", k), 32'h0, 5'd0,
                       1'b0, 1'b0);
        end

        // Pointer wrap after a grant to 30
        do_reset();
        req = 32'h4000_0000;
        tick();
        expect_out("wrap30", 32'h4000_0000, 5'd30, 1'b1, 1'b0);
        req = 32'h0;
        tick();
        req = BOTH;
        tick();
        expect_out("wrap31", 32'h8000_0000, 5'd31, 1'b1, 1'b0);
        req = 32'h1;
        tick();
        expect_out("wrap_gap", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("wrap0", 32'h1, 5'd0, 1'b1, 1'b0);

        // Hold limit, regrant of the lone requester, then handoff
        do_reset();
        req = 32'h20;
        for (int c = 0; c < HOLD; c++) begin
            tick();
            expect_out("lim_hold", 32'h20, 5'd5, 1'b1, 1'b0);
        end
        tick();
        expect_out("lim_to", 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        expect_out("lim_regrant", 32'h20, 5'd5, 1'b1, 1'b0);
        req = 32'h60;
        for (int c = 1; c < HOLD; c++) begin
            tick();
            expect_out("lim_hold2", 32'h20, 5'd5, 1'b1, 1'b0);
        end
        tick();
        expect_out("lim_to2", 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        expect_out("lim_hand", 32'h40, 5'd6, 1'b1, 1'b0);

        // Release coinciding with the limit cycle
        do_reset();
        req = 32'h20;
        for (int c = 0; c < HOLD; c++) tick();
        expect_out("tie_last", 32'h20, 5'd5, 1'b1, 1'b0);
        req = 32'h0;
        tick();
        expect_out("tie_end", 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("tie_after", 32'h0, 5'd0, 1'b0, 1'b0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            clear = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 3);
                case (r)
                    0: req = '0;
                    1: req = 32'd1 << $urandom_range(0, 31);
                    2: req = (32'd1 << $urandom_range(0, 31)) |
                             (32'd1 << $urandom_range(0, 31));
                    default: req = $urandom;
                endcase
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
